// File: rtl/activation_stream.sv
// activation_stream: streaming per-frame-selectable activation over a
// raster-order pixel stream. Each beat carries CHANNELS signed PX_SIZE values
// for one pixel position. The pipeline has two stages. Stage 1 holds the raw
// beat, its frame-position flags and the latched mode. Stage 2 holds the
// activated result and drives the outputs.
//
// Ports:
//   clk, rst          clock; asynchronous active-high reset
//   mode, clip_max    activation select (0 relu, 1 leaky, 2 clipped, 3 identity)
//                     and clip bound; both sampled on a frame's first beat
//   in_valid/ready    input handshake, in_data = CHANNELS x PX_SIZE packed
//   out_valid/ready   output handshake, out_data uses the same packing
//   out_first/last    beat is pixel (0,0) / final pixel of its frame
//   frame_done        one-cycle pulse after the out_last beat is accepted
module activation_stream #(
   parameter int INPUT_SIZE = 5,
   parameter int PX_SIZE    = 8,
   parameter int CHANNELS   = 1,
   parameter int LEAK_SHIFT = 3
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [1:0]                  mode,
   input  logic [PX_SIZE-1:0]          clip_max,
   input  logic                        in_valid,
   output logic                        in_ready,
   input  logic [CHANNELS*PX_SIZE-1:0] in_data,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic [CHANNELS*PX_SIZE-1:0] out_data,
   output logic                        out_first,
   output logic                        out_last,
   output logic                        frame_done
);

   localparam int DW   = CHANNELS * PX_SIZE;
   localparam int NPIX = INPUT_SIZE * INPUT_SIZE;
   localparam int CW   = (NPIX > 1) ? $clog2(NPIX) : 1;
   localparam logic [CW-1:0] LAST_CNT = CW'(NPIX - 1);

   // Gates in_ready low for the first cycle after reset release.
   logic          ready_en;

   logic [CW-1:0] count;
   logic [1:0]    cur_mode;
   logic [PX_SIZE-1:0] cur_clip;

   logic          s1_valid;
   logic [DW-1:0] s1_data;
   logic          s1_first;
   logic          s1_last;
   logic [1:0]    s1_mode;
   logic [PX_SIZE-1:0] s1_clip;

   logic          s2_adv;
   logic          s1_adv;
   logic          in_acc;
   logic          first_beat;
   logic [DW-1:0] act_data;

   assign s2_adv     = !out_valid || out_ready;
   assign s1_adv     = s1_valid && s2_adv;
   assign in_ready   = ready_en && (!s1_valid || s2_adv);
   assign in_acc     = in_valid && in_ready;
   assign first_beat = (count == '0);

   function automatic logic [PX_SIZE-1:0] act(
      input logic [PX_SIZE-1:0] x,
      input logic [1:0]         m,
      input logic [PX_SIZE-1:0] c
   );
      logic neg;
      logic [PX_SIZE-1:0] y;
      neg = x[PX_SIZE-1];
      y   = x;
      case (m)
         2'd0: y = neg ? '0 : x;
         2'd1: y = neg ? PX_SIZE'($signed(x) >>> LEAK_SHIFT) : x;
         2'd2: begin
            y = neg ? '0 : x;
            // A non-positive bound clips everything to zero.
            if (c[PX_SIZE-1] || c == '0)
               y = '0;
            else if ($signed(y) > $signed(c))
               y = c;
         end
         default: y = x;
      endcase
      return y;
   endfunction

   for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
      assign act_data[c*PX_SIZE +: PX_SIZE] =
         act(s1_data[c*PX_SIZE +: PX_SIZE], s1_mode, s1_clip);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         ready_en <= 1'b0;
      else
         ready_en <= 1'b1;
   end

   // Frame position counter and per-frame mode latch.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count    <= '0;
         cur_mode <= '0;
         cur_clip <= '0;
      end else if (in_acc) begin
         count <= (count == LAST_CNT) ? '0 : count + 1'b1;
         if (first_beat) begin
            cur_mode <= mode;
            cur_clip <= clip_max;
         end
      end
   end

   // Stage 1: raw beat plus flags. The first beat of a frame takes the live
   // mode/clip since the latch only updates at the same edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_valid <= 1'b0;
         s1_data  <= '0;
         s1_first <= 1'b0;
         s1_last  <= 1'b0;
         s1_mode  <= '0;
         s1_clip  <= '0;
      end else if (in_ready) begin
         s1_valid <= in_valid;
         if (in_valid) begin
            s1_data  <= in_data;
            s1_first <= first_beat;
            s1_last  <= (count == LAST_CNT);
            s1_mode  <= first_beat ? mode : cur_mode;
            s1_clip  <= first_beat ? clip_max : cur_clip;
         end
      end
   end

   // Stage 2: activated output register, held while stalled.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_first <= 1'b0;
         out_last  <= 1'b0;
      end else if (s2_adv) begin
         out_valid <= s1_valid;
         if (s1_valid) begin
            out_data  <= act_data;
            out_first <= s1_first;
            out_last  <= s1_last;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         frame_done <= 1'b0;
      else
         frame_done <= out_valid && out_ready && out_last;
   end

endmodule

// File: tb/tb_activation_stream.sv
// Scoreboard bench for activation_stream (PX_SIZE=8, CHANNELS=2, 5x5 frames).
module tb_activation_stream;

   localparam int PX   = 8;
   localparam int CH   = 2;
   localparam int DW   = PX * CH;
   localparam int NPIX = 25;
   localparam int LS   = 3;

   logic          clk = 1'b0;
   logic          rst;
   logic [1:0]    mode;
   logic [PX-1:0] clip_max;
   logic          in_valid;
   logic          in_ready;
   logic [DW-1:0] in_data;
   logic          out_valid;
   logic          out_ready;
   logic [DW-1:0] out_data;
   logic          out_first;
   logic          out_last;
   logic          frame_done;

   activation_stream #(.INPUT_SIZE(5), .PX_SIZE(PX), .CHANNELS(CH), .LEAK_SHIFT(LS)) dut (
      .clk(clk), .rst(rst), .mode(mode), .clip_max(clip_max),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_first(out_first), .out_last(out_last), .frame_done(frame_done)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [DW-1:0] d;
      logic [1:0]    m;
      logic [PX-1:0] c;
      bit            ov;
      logic [DW-1:0] e;
   } beat_t;

   typedef struct {
      logic [DW-1:0] d;
      bit            f;
      bit            l;
      int            t;
   } exp_t;

   beat_t src_q[$];
   exp_t  sb_q[$];

   int n_chk = 0;
   int n_err = 0;
   int cyc = 0;
   int n_acc = 0;
   int fd_cnt = 0;
   int rdy_pct = 100;
   int nb = 0;
   bit chk_lat = 0;
   bit fd_exp = 0;
   bit stalled = 0;
   logic [DW+2:0] held;

   int            m_cnt = 0;
   logic [1:0]    m_mode = 0;
   logic [PX-1:0] m_clip = 0;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
      end
   endtask

   function automatic logic [PX-1:0] ref_act(input logic [PX-1:0] xb, input logic [1:0] m,
                                             input logic [PX-1:0] cb);
      int x, c, y;
      x = $signed(xb);
      c = $signed(cb);
      case (m)
         2'd0: y = (x > 0) ? x : 0;
         2'd1: y = (x >= 0) ? x : -((-x + (1 << LS) - 1) / (1 << LS));
         2'd2: begin
            y = (x > 0) ? x : 0;
            if (c <= 0) y = 0;
            else if (y > c) y = c;
         end
         default: y = x;
      endcase
      return y[PX-1:0];
   endfunction

   task automatic add_beat(input logic [DW-1:0] d, input logic [1:0] m, input logic [PX-1:0] c,
                           input bit ov, input logic [DW-1:0] e);
      beat_t b;
      b.d = d; b.m = m; b.c = c; b.ov = ov; b.e = e;
      src_q.push_back(b);
      nb = (nb + 1) % NPIX;
   endtask

   task automatic fill(input logic [1:0] m, input logic [PX-1:0] c);
      while (nb != 0) add_beat(DW'($urandom), m, c, 0, '0);
   endtask

   // One clock: drive at negedge, sample #1 later (before the next posedge),
   // and resolve both handshakes for that coming edge.
   task automatic cycle();
      exp_t e;
      @(negedge clk);
      if (src_q.size() > 0) begin
         in_valid = 1'b1;
         in_data  = src_q[0].d;
         mode     = src_q[0].m;
         clip_max = src_q[0].c;
      end else begin
         in_valid = 1'b0;
      end
      out_ready = ($urandom_range(99) < rdy_pct);
      #1;
      if (stalled) chk("hold", 32'({out_valid, out_first, out_last, out_data}), 32'(held));
      stalled = out_valid && !out_ready;
      held    = {out_valid, out_first, out_last, out_data};
      if (fd_exp || frame_done) chk("frame_done", 32'(frame_done), 32'(fd_exp));
      if (frame_done) fd_cnt++;
      fd_exp = out_valid && out_ready && out_last;
      if (out_valid && out_ready) begin
         if (sb_q.size() == 0) begin
            chk("spurious_out", 32'(out_data), 32'hDEAD);
         end else begin
            e = sb_q.pop_front();
            chk("out_data", 32'(out_data), 32'(e.d));
            chk("out_first", 32'(out_first), 32'(e.f));
            chk("out_last", 32'(out_last), 32'(e.l));
            if (chk_lat) chk("latency", 32'(cyc - e.t), 32'd2);
         end
      end
      if (in_valid && in_ready) begin
         if (m_cnt == 0) begin
            m_mode = mode;
            m_clip = clip_max;
         end
         for (int c = 0; c < CH; c++)
            e.d[c*PX +: PX] = ref_act(in_data[c*PX +: PX], m_mode, m_clip);
         if (src_q[0].ov) e.d = src_q[0].e;
         e.f = (m_cnt == 0);
         e.l = (m_cnt == NPIX - 1);
         e.t = cyc;
         sb_q.push_back(e);
         m_cnt = (m_cnt == NPIX - 1) ? 0 : m_cnt + 1;
         n_acc++;
         void'(src_q.pop_front());
      end
      cyc++;
   endtask

   task automatic drain(input string tag);
      int n = 0;
      while ((src_q.size() > 0 || sb_q.size() > 0) && n < 3000) begin
         cycle();
         n++;
      end
      if (n >= 3000) chk({tag, "_timeout"}, 32'(sb_q.size() + src_q.size()), 32'd0);
      repeat (2) cycle();
   endtask

   task automatic chk_reset_state(input string tag);
      chk({tag, "_out_valid"}, 32'(out_valid), 0);
      chk({tag, "_out_data"}, 32'(out_data), 0);
      chk({tag, "_flags"}, 32'({out_first, out_last, frame_done}), 0);
   endtask

   logic [PX-1:0] lk_in[5] = '{8'hF0, 8'hFF, 8'h80, 8'h00, 8'h64};
   logic [PX-1:0] lk_ex[5] = '{8'hFE, 8'hFF, 8'hF0, 8'h00, 8'h64};
   logic [PX-1:0] cl_in[4] = '{8'hFD, 8'h04, 8'h06, 8'h5A};
   logic [PX-1:0] cl_ex[4] = '{8'h00, 8'h04, 8'h06, 8'h06};

   initial begin
      int fd0, acc0;
      rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
      mode = 2'd0; clip_max = '0;
      repeat (3) @(negedge clk);
      #1 chk_reset_state("reset");
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1 chk("in_ready_after_rst", 32'(in_ready), 1);

      // ReLU, one full frame, fixed latency
      fd0 = fd_cnt; chk_lat = 1;
      add_beat(16'hFB07, 2'd0, 8'd0, 1, 16'h0007);
      fill(2'd0, 8'd0);
      drain("relu");
      chk("relu_frames", 32'(fd_cnt - fd0), 1);
      chk_lat = 0;

      // Leaky ReLU
      for (int i = 0; i < 5; i++)
         add_beat({lk_in[i], lk_in[i]}, 2'd1, 8'd0, 1, {lk_ex[i], lk_ex[i]});
      fill(2'd1, 8'd0);
      // Clipped, bound 6 then bound -2
      for (int i = 0; i < 4; i++)
         add_beat({cl_in[i], cl_in[i]}, 2'd2, 8'd6, 1, {cl_ex[i], cl_ex[i]});
      fill(2'd2, 8'd6);
      for (int i = 0; i < 4; i++)
         add_beat({cl_in[i], cl_in[i]}, 2'd2, 8'hFE, 1, 16'h0000);
      fill(2'd2, 8'hFE);
      drain("arith");

      // Mode change mid-frame is ignored until the next frame
      for (int i = 0; i < 12; i++) add_beat(DW'($urandom), (i < 10) ? 2'd0 : 2'd3, 8'd0, 0, '0);
      add_beat(16'hFCFC, 2'd3, 8'd0, 1, 16'h0000);
      fill(2'd3, 8'd0);
      add_beat(16'hFCFC, 2'd3, 8'd0, 1, 16'hFCFC);
      fill(2'd3, 8'd0);
      drain("latch");

      // Full stall: at most two beats buffered, then random backpressure
      fd0 = fd_cnt;
      rdy_pct = 0;
      for (int f = 0; f < 3; f++) begin
         logic [1:0] m;
         m = 2'($urandom);
         add_beat(DW'($urandom), m, 8'($urandom_range(1, 100)), 0, '0);
         fill(m, 8'($urandom_range(1, 100)));
      end
      acc0 = n_acc;
      repeat (8) cycle();
      chk("stall_accepts", 32'(n_acc - acc0), 2);
      chk("stall_valid", 32'(out_valid), 1);
      rdy_pct = 50;
      drain("bp");
      chk("bp_frames", 32'(fd_cnt - fd0), 3);
      rdy_pct = 100;

      // Reset after 13 beats of a frame
      for (int i = 0; i < NPIX; i++) add_beat(DW'($urandom), 2'd0, 8'd0, 0, '0);
      while (m_cnt != 13) cycle();
      @(negedge clk);
      rst = 1'b1; in_valid = 1'b0;
      #1 chk_reset_state("midrst");
      src_q.delete(); sb_q.delete();
      m_cnt = 0; m_mode = 0; m_clip = 0; nb = 0;
      fd_exp = 0; stalled = 0;
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1 chk("in_ready_after_midrst", 32'(in_ready), 1);
      fd0 = fd_cnt;
      for (int i = 0; i < NPIX; i++) add_beat(DW'($urandom), 2'd1, 8'd0, 0, '0);
      drain("post_rst");
      chk("post_rst_frames", 32'(fd_cnt - fd0), 1);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
